layer_wr_ctl: RTL and testbench
===============================

Name: layer_wr_ctl

Overview:
- Parametrised command/data byte-stream decoder for the LED cube frame store.
- Decodes the SPI-side byte stream (dc_in: 0 = command, 1 = data).
- Generates RAM write address, per-byte lane enables and per-layer write enables.
- Signals frame completion and aborted frames.
- Generalises the fixed 8-layer/64-pixel/RGB controller to arbitrary layer count, pixel count and colour bytes per pixel (RGB or RGBW), and adds a start-layer select command.

Parameters:
LAYERS, 8, number of cube layers (2..32)
PIXELS, 64, pixels per layer (power of two not required, >=2)
COLORS, 3, colour bytes per pixel (3 or 4)
ADDR_W, $clog2(PIXELS), width of wr_addr_out
CMD_ADDR_WR, 8'hcc, command: write address-map RAM
CMD_DATA_WR, 8'hda, command: write colour data from layer 0
CMD_LAYER_SEL, 8'hce, command: next data byte = start layer, then colour data

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
dc_in  in  1  0 = command byte, 1 = data byte; sampled with byte_rdy_in
byte_rdy_in  in  1  one-cycle strobe, byte_data_in valid
byte_data_in  in  8  received byte
wr_addr_out  out  ADDR_W  pixel address for current byte
byte_en_out  out  COLORS+1  bit COLORS = address lane; bits COLORS-1..0 = colour lane one-hot, MSB = first colour
layer_en_out  out  LAYERS  registered layer mask ANDed with byte_rdy_in (combinational gate)
frame_rdy_out  out  1  one-cycle pulse: full frame written
frame_abort_out  out  1  one-cycle pulse: frame interrupted or bad layer index
busy_out  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; wr_addr_out=0, byte_en_out=0, layer mask=0, frame_rdy_out=0, frame_abort_out=0, busy_out=0.
- All state is updated only on clk_in rising edges with byte_rdy_in=1; otherwise it holds.
- Command byte (dc_in=0), any state:
  - wr_addr_out is cleared to 0.
  - If state is DATA and any byte of the frame has been written, pulse frame_abort_out on the next cycle.
  - CMD_ADDR_WR -> ADDR: byte_en = {1, COLORS'b0}, mask all ones.
  - CMD_DATA_WR -> DATA: byte_en = {0, colour MSB one-hot}, mask = bit 0.
  - CMD_LAYER_SEL -> LSEL: byte_en = 0, mask = 0.
  - Any other command -> IDLE: byte_en = 0, mask = 0.
- ADDR, data byte: wr_addr_out increments. At PIXELS-1: wrap to 0, mask = 0, state IDLE.
- LSEL, data byte:
  - Value < LAYERS: mask = one-hot(value), colour = MSB, state DATA.
  - Value >= LAYERS: state IDLE, frame_abort_out pulse.
- DATA, data byte:
  - Colour one-hot rotates right (MSB toward bit 0).
  - On the byte where colour bit 0 is set, colour reloads MSB and wr_addr_out increments.
  - At the last colour of pixel PIXELS-1: wr_addr_out = 0 and the mask rotates left.
  - At the last colour of pixel PIXELS-1 in layer LAYERS-1: mask = 0, byte_en = 0, state IDLE, frame_rdy_out pulse.
- Data byte in IDLE: ignored.
- frame_rdy_out and frame_abort_out are registered, asserted exactly one cycle after the triggering byte_rdy_in cycle, and never high together.
- A frame started via LSEL at layer k completes after layers k..LAYERS-1 (no wrap to layer 0).
- Reset mid-frame: immediate return to reset values, no pulses.
- Output timing: wr_addr_out, byte_en_out and the layer mask present the values for the *current* byte during its byte_rdy_in cycle and update after it.

Decomposition:
- Package layer_wr_pkg:
  - state enum {IDLE, ADDR, LSEL, DATA}
  - default command constants
  - function onehot(idx, width)
- One sub-module: pixel_cursor.
  - Holds the colour one-hot, address and layer-mask counters.
  - Inputs: advance, load_start(layer).
  - Outputs: counters plus the last_pixel and last_layer flags.
- The FSM and pulse generation stay in layer_wr_ctl.

Test Plan:
- Default params, CMD_DATA_WR then 8*64*3 = 1536 data bytes -> layer_en walks 0x01..0x80; wr_addr_out 0..63 per layer; colour 100,010,001 per pixel; frame_rdy_out single pulse one cycle after byte 1536; state IDLE.
- CMD_ADDR_WR then 64 data bytes -> byte_en_out = 4'b1000; layer_en_out = 0xFF during strobes; wr_addr_out 0..63; after byte 64 mask = 0; no frame_rdy_out.
- CMD_LAYER_SEL, data 0x05, then 3*64*3 = 576 bytes -> writes only layers 5, 6, 7; frame_rdy_out pulses once. CMD_LAYER_SEL with data 0x08 -> frame_abort_out pulse, IDLE.
- CMD_DATA_WR, 100 data bytes, then CMD_DATA_WR -> frame_abort_out pulse; wr_addr_out = 0; layer_en = 0x01; colour MSB; next frame completes normally.
- COLORS=4, LAYERS=4, PIXELS=16: full frame of 256 bytes -> colour 1000..0001 per pixel; frame_rdy_out after byte 256. Assert rst_n_in low at byte 130 -> all outputs 0 immediately, no pulses.
- byte_rdy_in held low for random gaps of 0..5 cycles between bytes -> identical address/enable sequence to the back-to-back run; layer_en_out = 0 whenever byte_rdy_in = 0.

Source files
------------

// File: rtl/layer_wr_pkg.sv
// Shared types and helpers for the LED cube frame-store write controller.
package layer_wr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LSEL,
        DATA
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_CLEAR,
        CUR_ADDR_MODE,
        CUR_LOAD,
        CUR_STEP_ADDR,
        CUR_STEP_DATA
    } cur_op_t;

    localparam logic [7:0] DEF_CMD_ADDR_WR   = 8'hcc;
    localparam logic [7:0] DEF_CMD_DATA_WR   = 8'hda;
    localparam logic [7:0] DEF_CMD_LAYER_SEL = 8'hce;

    function automatic logic [31:0] onehot(input logic [7:0] idx, input int unsigned width);
        onehot = '0;
        if (32'(idx) < width) onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/layer_wr_ctl_pixel_cursor.sv
// Colour lane, pixel address and layer mask counters walked by the write controller.
module pixel_cursor
    import layer_wr_pkg::*;
#(
    parameter int LAYERS = 8,
    parameter int PIXELS = 64,
    parameter int COLORS = 3,
    parameter int ADDR_W = $clog2(PIXELS)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  cur_op_t           op_i,
    input  logic [7:0]        layer_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [COLORS-1:0] colour_o,
    output logic [LAYERS-1:0] mask_o,
    output logic              last_pixel_o,
    output logic              last_colour_o,
    output logic              last_layer_o
);

    localparam logic [COLORS-1:0] COL_MSB   = {1'b1, {(COLORS-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COLORS-1:0] colour_q, colour_d;
    logic [LAYERS-1:0] mask_q, mask_d;

    assign last_pixel_o  = (addr_q == ADDR_LAST);
    assign last_colour_o = colour_q[0];
    assign last_layer_o  = mask_q[LAYERS-1];
    assign addr_o        = addr_q;
    assign colour_o      = colour_q;
    assign mask_o        = mask_q;

    always_comb begin
        addr_d   = addr_q;
        colour_d = colour_q;
        mask_d   = mask_q;
        case (op_i)
            CUR_CLEAR: begin
                addr_d   = '0;
                colour_d = '0;
                mask_d   = '0;
            end
            CUR_ADDR_MODE: begin
                addr_d   = '0;
                colour_d = '0;
                mask_d   = '1;
            end
            CUR_LOAD: begin
                addr_d   = '0;
                colour_d = COL_MSB;
                mask_d   = LAYERS'(onehot(layer_i, LAYERS));
            end
            CUR_STEP_ADDR: begin
                if (last_pixel_o) begin
                    addr_d = '0;
                    mask_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            CUR_STEP_DATA: begin
                if (!colour_q[0]) begin
                    colour_d = colour_q >> 1;
                end else begin
                    colour_d = COL_MSB;
                    if (last_pixel_o) begin
                        addr_d = '0;
                        // Finishing the top layer ends the frame: all lanes go quiet.
                        if (last_layer_o) begin
                            mask_d   = '0;
                            colour_d = '0;
                        end else begin
                            mask_d = {mask_q[LAYERS-2:0], mask_q[LAYERS-1]};
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= '0;
            colour_q <= '0;
            mask_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            colour_q <= colour_d;
            mask_q   <= mask_d;
        end
    end

endmodule

// File: rtl/layer_wr_ctl.sv
// Command/data byte-stream decoder driving RAM address, lane enables and layer
// enables for the LED cube frame store; flags completed and aborted frames.
module layer_wr_ctl
    import layer_wr_pkg::*;
#(
    parameter int         LAYERS        = 8,
    parameter int         PIXELS        = 64,
    parameter int         COLORS        = 3,
    parameter int         ADDR_W        = $clog2(PIXELS),
    parameter logic [7:0] CMD_ADDR_WR   = DEF_CMD_ADDR_WR,
    parameter logic [7:0] CMD_DATA_WR   = DEF_CMD_DATA_WR,
    parameter logic [7:0] CMD_LAYER_SEL = DEF_CMD_LAYER_SEL
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              dc_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [COLORS:0]   byte_en_out,
    output logic [LAYERS-1:0] layer_en_out,
    output logic              frame_rdy_out,
    output logic              frame_abort_out,
    output logic              busy_out
);

    state_t            state_q, state_d;
    logic              wrote_q, wrote_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              abort_q, abort_d;
    cur_op_t           cur_op;
    logic [7:0]        load_layer;
    logic [COLORS-1:0] colour;
    logic [LAYERS-1:0] mask;
    logic              last_pixel, last_colour, last_layer;

    pixel_cursor #(
        .LAYERS (LAYERS),
        .PIXELS (PIXELS),
        .COLORS (COLORS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk_i         (clk_in),
        .rst_n_i       (rst_n_in),
        .op_i          (cur_op),
        .layer_i       (load_layer),
        .addr_o        (wr_addr_out),
        .colour_o      (colour),
        .mask_o        (mask),
        .last_pixel_o  (last_pixel),
        .last_colour_o (last_colour),
        .last_layer_o  (last_layer)
    );

    assign byte_en_out     = {state_q == ADDR, colour};
    assign layer_en_out    = mask & {LAYERS{byte_rdy_in}};
    assign busy_out        = (state_q != IDLE);
    assign frame_rdy_out   = frame_rdy_q;
    assign frame_abort_out = abort_q;

    always_comb begin
        state_d     = state_q;
        wrote_d     = wrote_q;
        frame_rdy_d = 1'b0;
        abort_d     = 1'b0;
        cur_op      = CUR_HOLD;
        load_layer  = '0;
        if (byte_rdy_in) begin
            if (!dc_in) begin
                wrote_d = 1'b0;
                abort_d = (state_q == DATA) && wrote_q;
                case (byte_data_in)
                    CMD_ADDR_WR: begin
                        state_d = ADDR;
                        cur_op  = CUR_ADDR_MODE;
                    end
                    CMD_DATA_WR: begin
                        state_d = DATA;
                        cur_op  = CUR_LOAD;
                    end
                    CMD_LAYER_SEL: begin
                        state_d = LSEL;
                        cur_op  = CUR_CLEAR;
                    end
                    default: begin
                        state_d = IDLE;
                        cur_op  = CUR_CLEAR;
                    end
                endcase
            end else begin
                case (state_q)
                    ADDR: begin
                        cur_op = CUR_STEP_ADDR;
                        if (last_pixel) state_d = IDLE;
                    end
                    LSEL: begin
                        if (int'(byte_data_in) < LAYERS) begin
                            state_d    = DATA;
                            cur_op     = CUR_LOAD;
                            load_layer = byte_data_in;
                        end else begin
                            state_d = IDLE;
                            cur_op  = CUR_CLEAR;
                            abort_d = 1'b1;
                        end
                    end
                    DATA: begin
                        cur_op  = CUR_STEP_DATA;
                        wrote_d = 1'b1;
                        if (last_colour && last_pixel && last_layer) begin
                            state_d     = IDLE;
                            wrote_d     = 1'b0;
                            frame_rdy_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            wrote_q     <= 1'b0;
            frame_rdy_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrote_q     <= wrote_d;
            frame_rdy_q <= frame_rdy_d;
            abort_q     <= abort_d;
        end
    end

endmodule

// File: tb/tb_layer_wr_ctl.sv
// Directed-plus-random bench for layer_wr_ctl: two configurations, each byte
// checked against a frame-position model (layer/pixel/colour from byte count).
module tb_layer_wr_ctl;

    localparam int M_IDLE = 0;
    localparam int M_ADDR = 1;
    localparam int M_LSEL = 2;
    localparam int M_DATA = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dc;
    logic       rdy;
    logic [7:0] data;
    logic       sel;
    logic       rdy_a, rdy_b;

    always #5 clk = ~clk;

    assign rdy_a = rdy & ~sel;
    assign rdy_b = rdy & sel;

    logic [5:0] addr_a;
    logic [3:0] ben_a;
    logic [7:0] len_a;
    logic       frdy_a, fab_a, busy_a;

    logic [3:0] addr_b;
    logic [4:0] ben_b;
    logic [3:0] len_b;
    logic       frdy_b, fab_b, busy_b;

    layer_wr_ctl dut_a (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .dc_in           (dc),
        .byte_rdy_in     (rdy_a),
        .byte_data_in    (data),
        .wr_addr_out     (addr_a),
        .byte_en_out     (ben_a),
        .layer_en_out    (len_a),
        .frame_rdy_out   (frdy_a),
        .frame_abort_out (fab_a),
        .busy_out        (busy_a)
    );

    layer_wr_ctl #(.LAYERS(4), .PIXELS(16), .COLORS(4)) dut_b (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .dc_in           (dc),
        .byte_rdy_in     (rdy_b),
        .byte_data_in    (data),
        .wr_addr_out     (addr_b),
        .byte_en_out     (ben_b),
        .layer_en_out    (len_b),
        .frame_rdy_out   (frdy_b),
        .frame_abort_out (fab_b),
        .busy_out        (busy_b)
    );

    logic [63:0] o_addr, o_ben, o_len;
    logic        o_rdy, o_ab, o_busy;

    assign o_addr = sel ? 64'(addr_b) : 64'(addr_a);
    assign o_ben  = sel ? 64'(ben_b)  : 64'(ben_a);
    assign o_len  = sel ? 64'(len_b)  : 64'(len_a);
    assign o_rdy  = sel ? frdy_b : frdy_a;
    assign o_ab   = sel ? fab_b  : fab_a;
    assign o_busy = sel ? busy_b : busy_a;

    int P, L, C;
    int mode, n, k;
    bit exp_rdy, exp_ab;
    int max_gap;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (mode=%0d n=%0d)", tag, obs, exp, mode, n);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        n    = 0;
        k    = 0;
    endtask

    // Expected outputs for the byte currently presented, from frame position alone.
    task automatic check_outputs();
        longint ea, eb, el;
        ea = 0;
        eb = 0;
        el = 0;
        if (mode == M_ADDR) begin
            ea = n;
            eb = 64'd1 << C;
            el = (64'd1 << L) - 1;
        end else if (mode == M_DATA) begin
            ea = (n / C) % P;
            eb = 64'd1 << (C - 1 - (n % C));
            el = 64'd1 << (k + n / (P * C));
        end
        chk("wr_addr", o_addr, ea);
        chk("byte_en", o_ben, eb);
        chk("layer_en", o_len, rdy ? el : 0);
        chk("busy", o_busy, 64'(mode != M_IDLE));
    endtask

    task automatic model_update(input bit d, input logic [7:0] v);
        exp_rdy = 1'b0;
        exp_ab  = 1'b0;
        if (!d) begin
            exp_ab = (mode == M_DATA) && (n > 0);
            n = 0;
            k = 0;
            case (v)
                8'hcc:   mode = M_ADDR;
                8'hda:   mode = M_DATA;
                8'hce:   mode = M_LSEL;
                default: mode = M_IDLE;
            endcase
        end else begin
            case (mode)
                M_ADDR: begin
                    n++;
                    if (n == P) begin
                        mode = M_IDLE;
                        n    = 0;
                    end
                end
                M_LSEL: begin
                    if (int'(v) < L) begin
                        k    = int'(v);
                        n    = 0;
                        mode = M_DATA;
                    end else begin
                        mode   = M_IDLE;
                        exp_ab = 1'b1;
                    end
                end
                M_DATA: begin
                    n++;
                    if (n == (L - k) * P * C) begin
                        mode    = M_IDLE;
                        n       = 0;
                        exp_rdy = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Entered shortly after a falling edge; returns shortly after a falling edge.
    task automatic send(input bit d, input logic [7:0] v);
        int g;
        dc   = d;
        data = v;
        rdy  = 1'b1;
        #1;
        check_outputs();
        @(posedge clk);
        model_update(d, v);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        chk("frame_rdy", 64'(o_rdy), 64'(exp_rdy));
        chk("frame_abort", 64'(o_ab), 64'(exp_ab));
        g = $urandom_range(0, max_gap);
        repeat (g) begin
            @(negedge clk);
            #1;
            chk("layer_en_gap", o_len, 0);
            chk("pulse_gap", {o_rdy, o_ab}, 0);
        end
    endtask

    task automatic send_data(input int count);
        for (int i = 0; i < count; i++) send(1'b1, 8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_ben"}, o_ben, 0);
        chk({tag, "_len"}, o_len, 0);
        chk({tag, "_pulses"}, {o_rdy, o_ab}, 0);
        chk({tag, "_busy"}, 64'(o_busy), 0);
    endtask

    initial begin
        logic [7:0] junk;
        rst_n   = 1'b0;
        dc      = 1'b0;
        rdy     = 1'b0;
        data    = 8'h00;
        sel     = 1'b0;
        max_gap = 0;
        P = 64;
        L = 8;
        C = 3;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst_a");
        sel = 1'b1;
        #1;
        check_reset_outputs("rst_b");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Address-map write, then a stray data byte while idle.
        send(1'b0, 8'hcc);
        send_data(64);
        send(1'b1, 8'h5a);

        // Full frame from layer 0.
        send(1'b0, 8'hda);
        send_data(8 * 64 * 3);
        send(1'b1, 8'h11);

        // Start-layer select: valid layer 5, then out-of-range layer 8.
        send(1'b0, 8'hce);
        send(1'b1, 8'h05);
        send_data(3 * 64 * 3);
        send(1'b0, 8'hce);
        send(1'b1, 8'h08);
        send(1'b1, 8'h00);

        // Interrupted frame, restart, complete.
        send(1'b0, 8'hda);
        send_data(100);
        send(1'b0, 8'hda);
        send_data(8 * 64 * 3);

        // Unknown command mid-frame.
        do junk = 8'($urandom); while (junk == 8'hcc || junk == 8'hda || junk == 8'hce);
        send(1'b0, 8'hda);
        send_data($urandom_range(1, 300));
        send(1'b0, junk);
        send(1'b1, 8'h33);

        // Random gaps between bytes.
        max_gap = 5;
        send(1'b0, 8'hce);
        send(1'b1, 8'($urandom_range(0, 7)));
        send_data((L - k) * P * C);
        send(1'b0, 8'hda);
        send_data(8 * 64 * 3);
        send(1'b0, 8'hcc);
        send_data(64);

        // Second configuration: 4 layers, 16 pixels, RGBW.
        sel = 1'b1;
        P = 16;
        L = 4;
        C = 4;
        model_reset();
        max_gap = 2;
        #1;
        send(1'b0, 8'hda);
        send_data(4 * 16 * 4);
        send(1'b0, 8'hce);
        send(1'b1, 8'h04);
        send(1'b0, 8'hce);
        send(1'b1, 8'h03);
        send_data(16 * 4);

        // Reset asserted while byte 130 is presented.
        max_gap = 0;
        send(1'b0, 8'hda);
        send_data(129);
        dc   = 1'b1;
        data = 8'h77;
        rdy  = 1'b1;
        #1;
        check_outputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_outputs("midrst_hold");
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        send(1'b1, 8'h01);
        send(1'b0, 8'hda);
        send_data(4 * 16 * 4);
        send(1'b1, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
